ph_pattern_gen: RTL and testbench
=================================

# ph_pattern_gen

Parametrised phi pattern detector, the next generation of the per-key-strip pattern matcher in the primitive-conversion-to-sorter chain. For each key strip it evaluates NPAT configurable straightness patterns over the ST1/ST2/ST3/ST4 hit rasters. It tracks per-pattern, per-fold hit history over a programmable drift window and outputs the best quality code. Alongside the code it reports the winning pattern index and the fold tag. New over the previous generation: run-time drift time, mask-defined patterns, async reset, a 2-stage pipeline, and an out-of-range fold guard.

## Interface
- NPAT, 5: number of patterns, 1..8; pattern index is its straightness.
- FOLD, 3: clocks per bx (fold count).
- ST1_W, 31: ST1 raster width.
- ST3_W, 15: ST3/ST4 raster width.
- DT_MAX, 3: maximum drift time in bx; history depth is DT_MAX+1.
- ST1_MASK, default 5-pattern layout: NPAT*ST1_W packed; slice p selects the ST1 bits of pattern p. Default p0 = bits 30:23 and 7:0, p1 = 22:19 and 11:8, p2 = 18:17 and 13:12, p3 = 16 and 14, p4 = 15.
- ST3_MASK, default: NPAT*ST3_W packed; slice p covers ST3 and ST4. Default p0 = 14:0, p1 = 14:0, p2 = 10:4, p3 = 8:6, p4 = 7.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- st1  in  ST1_W  ST1 hits
- st2  in  1  ST2 key-strip hit
- st3  in  ST3_W  ST3 hits
- st4  in  ST3_W  ST4 hits
- drifttime  in  3  drift time in bx
- foldn  in  3  current fold, 0..FOLD-1
- qcode  out  6  best quality code
- qpat  out  3  winning pattern index
- qfold  out  3  fold tag of the output
- qvalid  out  1  qcode non-zero

## Operation
- Layer bits for pattern p:
  - ly[2] = |(st1 & ST1_MASK[p]).
  - ly[1] = st2.
  - ly[0] = |((st3 | st4) & ST3_MASK[p]).
- Hit-count flags: multi = at least 2 of the 3 ly bits set. any = ly != 0.
- Effective drift: dt = drifttime clamped to 1..DT_MAX. drifttime 0 gives 1; values above DT_MAX give DT_MAX.
- History: sh[p][f][DT_MAX:0]. sh[k] holds `any` from k+1 bx earlier in the same fold f.
- Fire condition: foldn < FOLD, sh[dt-1]==1, sh[dt]==0, and multi on the current inputs.
- On fire, qp[p] = {s[2], ly[2], s[1], ly[1], s[0], ly[0]}, where s = p as 3 bits. Otherwise qp[p] = 0.
- History update, only when foldn < FOLD: sh[p][foldn] <= {sh[DT_MAX-1:0], any}. Histories of all other folds hold.
- foldn >= FOLD: no history update, all qp = 0, and qfold carries the raw foldn.
- Selection: qcode = max over p of qp[p]. qpat = the winning index.
  - Equal non-zero codes are impossible because straightness is embedded in the code.
  - When all qp are 0: qcode = 0 and qpat = 0.
- qvalid = (qcode != 0).
- drifttime change mid-run: takes effect on the next sampled clock; history is not cleared.
- Reset (rst_n low, any time, asynchronous):
  - All histories, stage-1 registers, qcode, qpat, qfold and qvalid go to 0.
  - Histories refill from empty after release; no fire occurs until dt+1 bx of history exist.

## Timing
- Stage 1, at clk edge N: sample inputs, compute qp[p], register qp and foldn, update history.
- Stage 2, at edge N+1: max tree, register qcode, qpat, qfold and qvalid.
- Latency: outputs correspond to the inputs sampled 2 clocks earlier. Throughput is one result per clock.
- One bx spans FOLD consecutive clocks. Fold f of bx n and fold f of bx n+1 are FOLD clocks apart.
- Reset release: the first edge with rst_n high is a normal sample.

## Test plan
- Straight track, FOLD=3, dt=2. On fold 0, hold st1[15]=1, st2=1, st3[7]=1 for bx n..n+2, all else 0.
  - Required: qcode=0x35, qpat=4, qfold=0, qvalid=1, two clocks after bx n+2 fold 0.
  - Required: qcode=0 for fold-0 samples of bx n and n+1.
- Same stimulus with drifttime=1 -> fire on bx n+1 fold 0 with qcode=0x35. drifttime=0 behaves identically. drifttime=7 with DT_MAX=3 -> fire on bx n+3.
- Single layer only, st2=1 for 4 bx -> qcode stays 0, and the history still fills: switching to 3 layers at bx n+2 gives no fire, because sh[dt] is already 1.
- Fold isolation: the hit pattern is applied only on fold 1 -> fires appear only with qfold=1. Folds 0 and 2 stay 0. foldn=5 -> qcode=0, qfold=5, histories unchanged.
- Wide track, st1[0]=1, st2=1, st3[0]=1 held 3 bx -> qcode={0,1,0,1,0,1}=0x15, qpat=0.
- Reset mid-run: assert rst_n low for 1 clock between bx n+1 and n+2 of the straight-track case.
  - Required: outputs go to 0 immediately.
  - Required: no fire until bx n+4, counting from the first post-reset bx with 3 more bx of hits.

Source files
------------

// File: rtl/ph_pattern_gen.sv
// ph_pattern_gen: phi pattern detector for one key strip.
// Each pattern collapses the ST1/ST3/ST4 rasters into three layer bits with its masks.
// It keeps a per-fold history of "any layer hit" over the drift window.
// A pattern fires when multi-layer hits arrive and the rising edge of that history
// sits exactly dt bx in the past. Stage 1 registers the per-pattern codes.
// Stage 2 picks the maximum code; straightness is embedded in the code's upper bits.
module ph_pattern_gen #(
    parameter int NPAT   = 5,
    parameter int FOLD   = 3,
    parameter int ST1_W  = 31,
    parameter int ST3_W  = 15,
    parameter int DT_MAX = 3,
    parameter logic [NPAT*ST1_W-1:0] ST1_MASK = {31'h0000_8000, 31'h0001_4000,
                                                 31'h0006_3000, 31'h0078_0F00,
                                                 31'h7F80_00FF},
    parameter logic [NPAT*ST3_W-1:0] ST3_MASK = {15'h0080, 15'h01C0, 15'h07F0,
                                                 15'h7FFF, 15'h7FFF}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ST1_W-1:0] st1,
    input  logic             st2,
    input  logic [ST3_W-1:0] st3,
    input  logic [ST3_W-1:0] st4,
    input  logic [2:0]       drifttime,
    input  logic [2:0]       foldn,
    output logic [5:0]       qcode,
    output logic [2:0]       qpat,
    output logic [2:0]       qfold,
    output logic             qvalid
);

    logic [2:0]           dt;
    logic                 fold_ok;
    logic [NPAT-1:0][5:0] qp_d;
    logic [NPAT-1:0][5:0] qp_q;
    logic [2:0]           fold_q;
    logic [5:0]           best_code;
    logic [2:0]           best_idx;
    logic [5:0]           qcode_q;
    logic [2:0]           qpat_q;
    logic [2:0]           qfold_q;
    logic                 qvalid_q;

    // Out-of-range folds neither fire nor touch any history.
    assign fold_ok = ({29'd0, foldn} < 32'(FOLD));

    // Effective drift time, clamped into 1..DT_MAX.
    always_comb begin
        if (drifttime == 3'd0) begin
            dt = 3'd1;
        end else if ({29'd0, drifttime} > 32'(DT_MAX)) begin
            dt = 3'(DT_MAX);
        end else begin
            dt = drifttime;
        end
    end

    for (genvar gi = 0; gi < NPAT; gi++) begin : g_pat
        localparam logic [2:0] PIDX = 3'(gi);

        logic [2:0]      ly;
        logic            any_hit;
        logic            multi;
        logic [DT_MAX:0] sh_q [FOLD];
        logic [DT_MAX:0] sh_cur;
        logic            sh_prev;
        logic            sh_old;

        assign ly[2]   = |(st1 & ST1_MASK[gi*ST1_W +: ST1_W]);
        assign ly[1]   = st2;
        assign ly[0]   = |((st3 | st4) & ST3_MASK[gi*ST3_W +: ST3_W]);
        assign any_hit = |ly;
        assign multi   = (ly[2] & ly[1]) | (ly[2] & ly[0]) | (ly[1] & ly[0]);

        // Select the history belonging to the fold currently presented.
        always_comb begin
            sh_cur = '0;
            for (int f = 0; f < FOLD; f++) begin
                if (foldn == 3'(f)) begin
                    sh_cur = sh_q[f];
                end
            end
        end

        // Tap the history at dt-1 (must be set) and dt (must be clear).
        always_comb begin
            sh_prev = 1'b0;
            sh_old  = 1'b0;
            for (int k = 1; k <= DT_MAX; k++) begin
                if (dt == 3'(k)) begin
                    sh_prev = sh_cur[k-1];
                    sh_old  = sh_cur[k];
                end
            end
        end

        assign qp_d[gi] = (fold_ok && sh_prev && !sh_old && multi) ?
                          {PIDX[2], ly[2], PIDX[1], ly[1], PIDX[0], ly[0]} : 6'd0;

        // Shift this bx's any-hit into the current fold's history; other folds hold.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int f = 0; f < FOLD; f++) begin
                    sh_q[f] <= '0;
                end
            end else begin
                for (int f = 0; f < FOLD; f++) begin
                    if (foldn == 3'(f)) begin
                        sh_q[f] <= {sh_q[f][DT_MAX-1:0], any_hit};
                    end
                end
            end
        end
    end

    // Stage 1: register per-pattern codes and the raw fold tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qp_q   <= '0;
            fold_q <= '0;
        end else begin
            qp_q   <= qp_d;
            fold_q <= foldn;
        end
    end

    // Maximum over pattern codes; ties only happen at zero, which leaves index 0.
    always_comb begin
        best_code = '0;
        best_idx  = '0;
        for (int p = 0; p < NPAT; p++) begin
            if (qp_q[p] > best_code) begin
                best_code = qp_q[p];
                best_idx  = 3'(p);
            end
        end
    end

    // Stage 2: register the winning code, its index and the fold tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qcode_q  <= '0;
            qpat_q   <= '0;
            qfold_q  <= '0;
            qvalid_q <= 1'b0;
        end else begin
            qcode_q  <= best_code;
            qpat_q   <= best_idx;
            qfold_q  <= fold_q;
            qvalid_q <= (best_code != 6'd0);
        end
    end

    assign qcode  = qcode_q;
    assign qpat   = qpat_q;
    assign qfold  = qfold_q;
    assign qvalid = qvalid_q;

endmodule

// File: tb/tb_ph_pattern_gen.sv
// tb_ph_pattern_gen: table-driven scenarios, hand sequences and randomized traffic
// checked against a queue-based reference model of the pattern detector.
module tb_ph_pattern_gen;
    localparam int NPAT   = 5;
    localparam int FOLD   = 3;
    localparam int DT_MAX = 3;

    localparam int K_H = 0;  // straight track, pattern 4
    localparam int K_W = 1;  // wide track, pattern 0
    localparam int K_T = 2;  // pattern 3 via ST4
    localparam int K_S = 3;  // ST2 only

    logic        clk = 1'b0;
    logic        rst_n;
    logic [30:0] st1;
    logic        st2;
    logic [14:0] st3;
    logic [14:0] st4;
    logic [2:0]  drifttime;
    logic [2:0]  foldn;
    logic [5:0]  qcode;
    logic [2:0]  qpat;
    logic [2:0]  qfold;
    logic        qvalid;

    int checks = 0;
    int errors = 0;

    ph_pattern_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st1       (st1),
        .st2       (st2),
        .st3       (st3),
        .st4       (st4),
        .drifttime (drifttime),
        .foldn     (foldn),
        .qcode     (qcode),
        .qpat      (qpat),
        .qfold     (qfold),
        .qvalid    (qvalid)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [30:0] m1 [NPAT];
    logic [14:0] m3 [NPAT];
    bit          hq [NPAT*FOLD][$];   // hq[i][k] = any-hit from k+1 bx ago
    logic [5:0]  m_code;
    logic [2:0]  m_pat;

    function automatic logic [30:0] span1(input int hi, input int lo);
        logic [30:0] r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [14:0] span3(input int hi, input int lo);
        logic [14:0] r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic bit hist_at(input int idx, input int k);
        if (k < hq[idx].size()) return hq[idx][k];
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NPAT*FOLD; i++) hq[i].delete();
    endtask

    task automatic model_eval();
        int dtv, l2, l1, l0, n, idx, code;
        if (drifttime == 3'd0) dtv = 1;
        else if (int'(drifttime) > DT_MAX) dtv = DT_MAX;
        else dtv = int'(drifttime);
        m_code = '0;
        m_pat  = '0;
        for (int p = 0; p < NPAT; p++) begin
            l2 = (|(st1 & m1[p])) ? 1 : 0;
            l1 = st2 ? 1 : 0;
            l0 = (|((st3 | st4) & m3[p])) ? 1 : 0;
            n  = l2 + l1 + l0;
            if (int'(foldn) < FOLD) begin
                idx = p*FOLD + int'(foldn);
                if (hist_at(idx, dtv-1) && !hist_at(idx, dtv) && n >= 2) begin
                    code = ((p >> 2) & 1)*32 + l2*16 + ((p >> 1) & 1)*8 + l1*4 + (p & 1)*2 + l0;
                    if (code > int'(m_code)) begin
                        m_code = 6'(code);
                        m_pat  = 3'(p);
                    end
                end
                hq[idx].push_front(n > 0);
                if (hq[idx].size() > DT_MAX+1) void'(hq[idx].pop_back());
            end
        end
    endtask

    // ---------------- checking ----------------
    bit         pend = 1'b0;
    string      p_name;
    logic [5:0] p_code;
    logic [2:0] p_pat;
    logic [2:0] p_fold;

    task automatic check(input string nm, input logic [5:0] ec, input logic [2:0] ep,
                         input logic [2:0] ef);
        logic ev;
        ev = (ec != 6'd0);
        checks++;
        if (qcode !== ec || qpat !== ep || qfold !== ef || qvalid !== ev) begin
            errors++;
            $display("FAIL %s: got qcode=%h qpat=%0d qfold=%0d qvalid=%0b, want qcode=%h qpat=%0d qfold=%0d qvalid=%0b",
                     nm, qcode, qpat, qfold, qvalid, ec, ep, ef, ev);
        end else begin
            $display("ok   %s: qcode=%h qpat=%0d qfold=%0d qvalid=%0b", nm, qcode, qpat, qfold, qvalid);
        end
    endtask

    // One clock: drive, sample edge, then check the result of the previous sample.
    task automatic step(input logic [30:0] a1, input logic a2, input logic [14:0] a3,
                        input logic [14:0] a4, input logic [2:0] dtv, input logic [2:0] fv,
                        input bit use_model, input logic [5:0] ec, input logic [2:0] ep,
                        input string nm);
        st1 = a1; st2 = a2; st3 = a3; st4 = a4; drifttime = dtv; foldn = fv;
        model_eval();
        @(posedge clk);
        @(negedge clk);
        if (pend) check(p_name, p_code, p_pat, p_fold);
        pend   = 1'b1;
        p_name = nm;
        p_fold = fv;
        if (use_model) begin
            p_code = m_code;
            p_pat  = m_pat;
        end else begin
            p_code = ec;
            p_pat  = ep;
        end
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        st1 = '0; st2 = 1'b0; st3 = '0; st4 = '0; drifttime = 3'd0; foldn = 3'd0;
        #1;
        check({nm, " async clear"}, 6'd0, 3'd0, 3'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        pend   = 1'b1;
        p_name = {nm, " first out"};
        p_code = '0;
        p_pat  = '0;
        p_fold = '0;
    endtask

    task automatic kind_inputs(input int kind, output logic [30:0] a1, output logic a2,
                               output logic [14:0] a3, output logic [14:0] a4);
        a1 = '0; a2 = 1'b1; a3 = '0; a4 = '0;
        case (kind)
            K_H: begin a1[15] = 1'b1; a3[7] = 1'b1; end
            K_W: begin a1[0]  = 1'b1; a3[0] = 1'b1; end
            K_T: begin a1[16] = 1'b1; a4[8] = 1'b1; end
            default: ;
        endcase
    endtask

    typedef struct {
        bit         clr;
        int         kind;
        logic [2:0] dtv;
        logic [2:0] hf;
        logic [5:0] ec;
        logic [2:0] ep;
    } vec_t;

    vec_t vt[$];

    logic [30:0] r1 [FOLD];
    logic        r2 [FOLD];
    logic [14:0] r3 [FOLD];
    logic [14:0] r4 [FOLD];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [30:0] a1;
        logic        a2;
        logic [14:0] a3, a4;
        logic [2:0]  dtr, fv;

        m1[0] = span1(30, 23) | span1(7, 0);
        m1[1] = span1(22, 19) | span1(11, 8);
        m1[2] = span1(18, 17) | span1(13, 12);
        m1[3] = span1(16, 16) | span1(14, 14);
        m1[4] = span1(15, 15);
        m3[0] = span3(14, 0);
        m3[1] = span3(14, 0);
        m3[2] = span3(10, 4);
        m3[3] = span3(8, 6);
        m3[4] = span3(7, 7);

        rst_n = 1'b1;
        st1 = '0; st2 = 1'b0; st3 = '0; st4 = '0; drifttime = 3'd0; foldn = 3'd0;

        // clr, kind, drift, hit fold, expected code/index for the hit-fold sample
        vt.push_back('{1'b1, K_H, 3'd2, 3'd0, 6'h00, 3'd0});  // straight dt=2
        vt.push_back('{1'b0, K_H, 3'd2, 3'd0, 6'h00, 3'd0});
        vt.push_back('{1'b0, K_H, 3'd2, 3'd0, 6'h35, 3'd4});
        vt.push_back('{1'b1, K_H, 3'd1, 3'd0, 6'h00, 3'd0});  // dt=1
        vt.push_back('{1'b0, K_H, 3'd1, 3'd0, 6'h35, 3'd4});
        vt.push_back('{1'b0, K_H, 3'd1, 3'd0, 6'h00, 3'd0});
        vt.push_back('{1'b1, K_H, 3'd0, 3'd0, 6'h00, 3'd0});  // dt=0 clamps to 1
        vt.push_back('{1'b0, K_H, 3'd0, 3'd0, 6'h35, 3'd4});
        vt.push_back('{1'b1, K_H, 3'd7, 3'd0, 6'h00, 3'd0});  // dt=7 clamps to 3
        vt.push_back('{1'b0, K_H, 3'd7, 3'd0, 6'h00, 3'd0});
        vt.push_back('{1'b0, K_H, 3'd7, 3'd0, 6'h00, 3'd0});
        vt.push_back('{1'b0, K_H, 3'd7, 3'd0, 6'h35, 3'd4});
        vt.push_back('{1'b1, K_S, 3'd2, 3'd0, 6'h00, 3'd0});  // single layer fills history
        vt.push_back('{1'b0, K_S, 3'd2, 3'd0, 6'h00, 3'd0});
        vt.push_back('{1'b0, K_S, 3'd2, 3'd0, 6'h00, 3'd0});
        vt.push_back('{1'b0, K_S, 3'd2, 3'd0, 6'h00, 3'd0});
        vt.push_back('{1'b0, K_H, 3'd2, 3'd0, 6'h00, 3'd0});
        vt.push_back('{1'b1, K_H, 3'd2, 3'd1, 6'h00, 3'd0});  // fold 1 only
        vt.push_back('{1'b0, K_H, 3'd2, 3'd1, 6'h00, 3'd0});
        vt.push_back('{1'b0, K_H, 3'd2, 3'd1, 6'h35, 3'd4});
        vt.push_back('{1'b1, K_W, 3'd2, 3'd0, 6'h00, 3'd0});  // wide track
        vt.push_back('{1'b0, K_W, 3'd2, 3'd0, 6'h00, 3'd0});
        vt.push_back('{1'b0, K_W, 3'd2, 3'd0, 6'h15, 3'd0});
        vt.push_back('{1'b1, K_T, 3'd2, 3'd0, 6'h00, 3'd0});  // pattern 3 via ST4
        vt.push_back('{1'b0, K_T, 3'd2, 3'd0, 6'h00, 3'd0});
        vt.push_back('{1'b0, K_T, 3'd2, 3'd0, 6'h1F, 3'd3});
        vt.push_back('{1'b1, K_H, 3'd3, 3'd0, 6'h00, 3'd0});  // drift change keeps history
        vt.push_back('{1'b0, K_H, 3'd3, 3'd0, 6'h00, 3'd0});
        vt.push_back('{1'b0, K_H, 3'd2, 3'd0, 6'h35, 3'd4});
        vt.push_back('{1'b1, K_H, 3'd2, 3'd0, 6'h00, 3'd0});  // reset between bx n+1 and n+2
        vt.push_back('{1'b0, K_H, 3'd2, 3'd0, 6'h00, 3'd0});
        vt.push_back('{1'b1, K_H, 3'd2, 3'd0, 6'h00, 3'd0});
        vt.push_back('{1'b0, K_H, 3'd2, 3'd0, 6'h00, 3'd0});
        vt.push_back('{1'b0, K_H, 3'd2, 3'd0, 6'h35, 3'd4});

        @(negedge clk);
        foreach (vt[i]) begin
            if (vt[i].clr) do_reset($sformatf("row%0d reset", i));
            kind_inputs(vt[i].kind, a1, a2, a3, a4);
            for (int f = 0; f < FOLD; f++) begin
                if (3'(f) == vt[i].hf)
                    step(a1, a2, a3, a4, vt[i].dtv, 3'(f), 1'b0, vt[i].ec, vt[i].ep,
                         $sformatf("row%0d fold%0d", i, f));
                else
                    step('0, 1'b0, '0, '0, vt[i].dtv, 3'(f), 1'b0, 6'h00, 3'd0,
                         $sformatf("row%0d fold%0d idle", i, f));
            end
        end

        // Out-of-range fold with hits must not disturb fold 1 history.
        do_reset("oor");
        kind_inputs(K_H, a1, a2, a3, a4);
        for (int b = 0; b < 2; b++) begin
            step('0, 1'b0, '0, '0, 3'd2, 3'd0, 1'b0, 6'h00, 3'd0, $sformatf("oor bx%0d f0", b));
            step(a1, a2, a3, a4, 3'd2, 3'd1, 1'b0, 6'h00, 3'd0, $sformatf("oor bx%0d f1", b));
            step('0, 1'b0, '0, '0, 3'd2, 3'd2, 1'b0, 6'h00, 3'd0, $sformatf("oor bx%0d f2", b));
        end
        step(a1, a2, a3, a4, 3'd2, 3'd5, 1'b0, 6'h00, 3'd0, "oor foldn5");
        step('0, 1'b0, '0, '0, 3'd2, 3'd0, 1'b0, 6'h00, 3'd0, "oor bx2 f0");
        step(a1, a2, a3, a4, 3'd2, 3'd1, 1'b0, 6'h35, 3'd4, "oor bx2 f1 fire");
        step('0, 1'b0, '0, '0, 3'd2, 3'd2, 1'b0, 6'h00, 3'd0, "oor bx2 f2");
        // Fire is on the outputs now; reset must clear them at once.
        do_reset("reset over fire");

        // Randomized traffic against the reference model.
        for (int f = 0; f < FOLD; f++) begin
            r1[f] = '0; r2[f] = 1'b0; r3[f] = '0; r4[f] = '0;
        end
        dtr = 3'd2;
        for (int cyc = 0; cyc < 900; cyc++) begin
            int f;
            f  = cyc % FOLD;
            fv = 3'(f);
            if ($urandom_range(0, 3) == 0) begin
                r1[f] = ($urandom_range(0, 2) == 0) ? 31'd0 : (31'd1 << $urandom_range(0, 30));
                if ($urandom_range(0, 3) == 0) r1[f] = r1[f] | (31'd1 << $urandom_range(0, 30));
                r2[f] = ($urandom_range(0, 2) != 0);
                r3[f] = ($urandom_range(0, 2) == 0) ? 15'd0 : (15'd1 << $urandom_range(0, 14));
                r4[f] = ($urandom_range(0, 3) != 0) ? 15'd0 : (15'd1 << $urandom_range(0, 14));
            end
            if ($urandom_range(0, 15) == 0) fv = 3'($urandom_range(FOLD, 7));
            if ($urandom_range(0, 40) == 0) dtr = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 300) == 0) do_reset($sformatf("rand%0d reset", cyc));
            step(r1[f], r2[f], r3[f], r4[f], dtr, fv, 1'b1, 6'h00, 3'd0,
                 $sformatf("rand%0d fold%0d dt%0d", cyc, fv, dtr));
        end
        step('0, 1'b0, '0, '0, 3'd2, 3'd0, 1'b1, 6'h00, 3'd0, "flush");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
